store_unit: RTL
===============

Name: store_unit

Overview:
- Store-side counterpart of the load decode path.
- Accepts one store request from the core per handshake: funct3, byte address, register data, and an AMO flag.
- Decodes the access size, checks alignment, builds word-aligned address / lane-replicated write data / byte strobes, and drives a valid/ready memory write port.
- Reports completion or a store-misaligned fault back to the core's trap logic.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- req_valid  input  1  core presents a store request.
- req_ready  output  1  unit can accept a request.
- funct3  input  3  store funct3; bits [1:0] select size.
- amo_data_store  input  1  AMO/SC write-back; forces word size.
- addr  input  XLEN  byte address.
- wdata  input  XLEN  rs2 data, LSB-aligned.
- mem_valid  output  1  write request to memory.
- mem_ready  input  1  memory accepts the write.
- mem_addr  output  XLEN  word-aligned address, bits [1:0] always 0.
- mem_wdata  output  XLEN  lane-positioned write data.
- mem_wstrb  output  4  byte strobes.
- done  output  1  one-cycle pulse: store fully written.
- store_misaligned  output  1  one-cycle pulse: store faulted, no memory write issued.
- fault_addr  output  XLEN  faulting byte address; valid with store_misaligned, held until next fault.

Behaviour:
- Reset: asynchronous and active-low. Reset value of every output is 0, except req_ready = 1.
- Reset is honoured in any state, including mid-transaction: state returns to IDLE and mem_valid drops immediately.
- Size decode:
  - funct3[1:0] = 00: byte.
  - funct3[1:0] = 01: half.
  - funct3[1:0] = 10: word.
  - funct3[1:0] = 11: reserved, decoded as word.
  - funct3[2] is ignored.
  - amo_data_store = 1 overrides funct3 to word.
- Alignment:
  - Byte stores are never misaligned.
  - Half is misaligned when addr[0] = 1.
  - Word is misaligned when addr[1:0] != 0.
- Lane data:
  - Byte: wdata[7:0] replicated to all 4 lanes, wstrb = 0001 << addr[1:0].
  - Half: wdata[15:0] replicated to both halves, wstrb = 0011 << addr[1:0].
  - Word: wdata, wstrb = 1111.
- FSM states: IDLE, ISSUE, ISSUE_HI (ISSUE_HI exists only with the optional feature), FAULT.
- IDLE:
  - req_ready = 1. On req_valid && req_ready, the request is latched.
  - Misaligned request: go to FAULT.
  - Aligned request: go to ISSUE.
- ISSUE:
  - mem_valid = 1.
  - mem_addr, mem_wdata and mem_wstrb are stable until mem_ready.
  - On mem_valid && mem_ready: go to IDLE and pulse done in the following cycle (or go to ISSUE_HI, see optional feature).
- FAULT:
  - Lasts one cycle. store_misaligned = 1 and fault_addr = latched addr.
  - No memory transaction is issued.
  - Returns to IDLE.
- req_ready is 0 in every state except IDLE; requests are never accepted back-to-back with an open transaction.
- Latency:
  - Accept at cycle N; mem_valid high at N+1.
  - done is high the cycle after the mem handshake, so minimum 2 cycles from accept to done with mem_ready tied high.
  - Misaligned fault pulse at N+1.
- done and store_misaligned are never high in the same cycle. In that cycle req_ready is already 1, so a new request may be accepted.
- mem_ready asserted while mem_valid = 0 is ignored.

Optional Feature:
- Macro: STORE_MISALIGNED_SPLIT_EN.
- Defined:
  - Misaligned half/word stores are not faulted. The unit forms an 8-bit strobe (size_mask << addr[1:0]) and 64-bit data (wdata << 8*addr[1:0]).
  - The low half is issued in ISSUE at addr & ~3.
  - If the high strobe half is nonzero, ISSUE_HI issues it at (addr & ~3) + 4, wrapping modulo 2^32.
  - A misaligned access contained in one word (e.g. sh at offset 1, strobe 0110) is a single beat.
  - done pulses only after the last beat; store_misaligned never asserts.
- Undefined: ISSUE_HI is absent and misaligned stores trap as described above.

Test Plan:
- sb, addr=0x1003, wdata=0x000000A5 -> one beat: mem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5; done one cycle after handshake.
- sh, addr=0x2002, wdata=0xBEEF, mem_ready held low 3 cycles -> mem_valid/addr/data/strb stable throughout (0x2000, 1100, 0xBEEFBEEF); req_ready=0 until done.
- sw, addr=0x3001 (macro off) -> store_misaligned pulse at N+1, fault_addr=0x3001, mem_valid never asserted.
- amo_data_store=1, funct3=000, addr=0x4000, wdata=0x12345678 -> word write, wstrb=1111, wdata=0x12345678.
- Macro on, sw addr=0xFFFFFFFE, wdata=0xAABBCCDD -> beat1 addr 0xFFFFFFFC, strb 1100, data 0xCCDD0000; beat2 addr 0x00000000, strb 0011, data 0x0000AABB; single done pulse.
- resetn low while in ISSUE with mem_valid=1 -> mem_valid, done, store_misaligned drop to 0 asynchronously; req_ready=1 after release; next store completes normally.

Source files
------------

// File: rtl/store_unit.sv
// Store path: size/alignment decode, lane-replicated write data and strobes, valid/ready memory write port.
// Optional STORE_MISALIGNED_SPLIT_EN splits misaligned half/word stores into up to two word beats instead of trapping.
module store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic            amo_data_store,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    output logic            done,
    output logic            store_misaligned,
    output logic [XLEN-1:0] fault_addr
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ISSUE    = 2'b01,
        FAULT    = 2'b10
`ifdef STORE_MISALIGNED_SPLIT_EN
        ,
        ISSUE_HI = 2'b11
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0] fault_addr_q, fault_addr_d;
    logic            done_q, done_d;

    logic [1:0]      size_sel;
    logic            is_byte;
    logic            is_half;
    logic [1:0]      off;
    logic            misaligned;
    logic [3:0]      size_mask;
    logic [XLEN-1:0] lane_data;
    logic [XLEN-1:0] word_addr;
    logic            accept;
    logic            unused_funct3;

    // funct3[2] only distinguishes load sign-extension; stores ignore it.
    assign unused_funct3 = funct3[2];

    assign size_sel   = amo_data_store ? 2'b10 : funct3[1:0];
    assign is_byte    = (size_sel == 2'b00);
    assign is_half    = (size_sel == 2'b01);
    assign off        = addr[1:0];
    assign misaligned = is_half ? off[0] : (!is_byte && (off != 2'b00));
    assign word_addr  = {addr[XLEN-1:2], 2'b00};
    assign size_mask  = is_byte ? 4'b0001 : (is_half ? 4'b0011 : 4'b1111);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_data[8*gi +: 8] = is_byte ? wdata[7:0]
                                        : is_half ? wdata[8*(gi%2) +: 8]
                                        :           wdata[8*gi +: 8];
        end
    endgenerate

`ifdef STORE_MISALIGNED_SPLIT_EN
    logic [7:0]        split_strb;
    logic [2*XLEN-1:0] split_data;
    logic [XLEN-1:0]   size_bits;
    logic [XLEN-1:0]   hi_wdata_q, hi_wdata_d;
    logic [3:0]        hi_wstrb_q, hi_wstrb_d;

    // Data is masked to the access size so bytes beyond it never reach the upper beat.
    assign size_bits  = is_byte ? XLEN'(32'h0000_00FF) : (is_half ? XLEN'(32'h0000_FFFF) : '1);
    assign split_strb = {4'b0000, size_mask} << off;
    assign split_data = {{XLEN{1'b0}}, wdata & size_bits} << {off, 3'b000};
`else
    logic [3:0] lane_strb;

    assign lane_strb = size_mask << off;
`endif

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        mem_valid = (state_q == ISSUE);
`ifdef STORE_MISALIGNED_SPLIT_EN
        if (state_q == ISSUE_HI) begin
            mem_valid = 1'b1;
        end
`endif
    end

    assign store_misaligned = (state_q == FAULT);
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign mem_wstrb        = mem_wstrb_q;
    assign done             = done_q;
    assign fault_addr       = fault_addr_q;

    always_comb begin
        state_d      = state_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        fault_addr_d = fault_addr_q;
        done_d       = 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
        hi_wdata_d   = hi_wdata_q;
        hi_wstrb_d   = hi_wstrb_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
                    state_d     = ISSUE;
                    mem_addr_d  = word_addr;
                    mem_wdata_d = misaligned ? split_data[XLEN-1:0] : lane_data;
                    mem_wstrb_d = split_strb[3:0];
                    hi_wdata_d  = split_data[2*XLEN-1:XLEN];
                    hi_wstrb_d  = split_strb[7:4];
`else
                    if (misaligned) begin
                        state_d      = FAULT;
                        fault_addr_d = addr;
                    end else begin
                        state_d     = ISSUE;
                        mem_addr_d  = word_addr;
                        mem_wdata_d = lane_data;
                        mem_wstrb_d = lane_strb;
                    end
`endif
                end
            end
            ISSUE: begin
                if (mem_ready) begin
`ifdef STORE_MISALIGNED_SPLIT_EN
                    // A second beat is only needed when the strobe spills past lane 3.
                    if (hi_wstrb_q != 4'b0000) begin
                        state_d     = ISSUE_HI;
                        mem_addr_d  = mem_addr_q + XLEN'(4);
                        mem_wdata_d = hi_wdata_q;
                        mem_wstrb_d = hi_wstrb_q;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef STORE_MISALIGNED_SPLIT_EN
            ISSUE_HI: begin
                if (mem_ready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            FAULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            fault_addr_q <= '0;
            done_q       <= 1'b0;
`ifdef STORE_MISALIGNED_SPLIT_EN
            hi_wdata_q   <= '0;
            hi_wstrb_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            fault_addr_q <= fault_addr_d;
            done_q       <= done_d;
`ifdef STORE_MISALIGNED_SPLIT_EN
            hi_wdata_q   <= hi_wdata_d;
            hi_wstrb_q   <= hi_wstrb_d;
`endif
        end
    end

endmodule
